// File: rtl/axibram_wcmd_sink.sv
// Write-command sink behind the AXI-to-BRAM write port: window-filters BRAM writes
// into a first-word-fall-through command FIFO and throttles upstream via dev_ready.
module axibram_wcmd_sink #(
    parameter int unsigned             ADDRESS_BITS    = 10,
    parameter int unsigned             FIFO_DEPTH_LOG2 = 4,
    parameter logic [ADDRESS_BITS-1:0] WIN_BASE        = '0,
    parameter logic [ADDRESS_BITS-1:0] WIN_MASK        = 10'h3C0,
    parameter int unsigned             READY_MARGIN    = 2
) (
    input  logic                       aclk,
    input  logic                       rst,
    input  logic [ADDRESS_BITS-1:0]    pre_awaddr,
    input  logic                       start_burst,
    output logic                       dev_ready,
    input  logic [ADDRESS_BITS-1:0]    bram_waddr,
    input  logic                       bram_wen,
    input  logic [3:0]                 bram_wstb,
    input  logic [31:0]                bram_wdata,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [ADDRESS_BITS-1:0]    cmd_addr,
    output logic [3:0]                 cmd_stb,
    output logic [31:0]                cmd_data,
    output logic [FIFO_DEPTH_LOG2:0]   fill,
    output logic                       err_over,
    output logic                       err_outside,
    input  logic                       err_clr
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned CMD_W = ADDRESS_BITS + 4 + 32;
    localparam int unsigned FILL_W = FIFO_DEPTH_LOG2 + 1;

    localparam logic [FIFO_DEPTH_LOG2:0] FILL_ZERO   = '0;
    localparam logic [FIFO_DEPTH_LOG2:0] FILL_ONE    = FILL_W'(1);
    localparam logic [FIFO_DEPTH_LOG2:0] FILL_FULL   = FILL_W'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0] READY_LIMIT = FILL_W'(DEPTH - READY_MARGIN);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = FIFO_DEPTH_LOG2'(1);

    logic                        r_sel;
    logic [CMD_W-1:0]            r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]    r_fill;
    logic [CMD_W-1:0]            r_head;
    logic                        r_err_over;
    logic                        r_err_outside;

    logic                        w_hit;
    logic [CMD_W-1:0]            w_cmd;
    logic                        w_full;
    logic                        w_pop;
    logic                        w_push_req;
    logic                        w_push;
    logic                        w_over_set;
    logic                        w_outside_set;
    logic [FIFO_DEPTH_LOG2-1:0]  w_rd_next;

    always_comb begin
        w_hit         = (pre_awaddr & WIN_MASK) == (WIN_BASE & WIN_MASK);
        w_cmd         = {bram_waddr & ~WIN_MASK, bram_wstb, bram_wdata};
        w_full        = (r_fill == FILL_FULL);
        w_pop         = (r_fill != FILL_ZERO) && cmd_ready;
        // r_sel is the pre-edge value, so a wen coinciding with start_burst
        // is judged against the burst it belongs to.
        w_push_req    = bram_wen && r_sel && (bram_wstb != 4'b0000);
        w_push        = w_push_req && (!w_full || w_pop);
        w_over_set    = w_push_req && w_full && !w_pop;
        w_outside_set = bram_wen && !r_sel;
        w_rd_next     = r_rd_ptr + PTR_ONE;
    end

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd;
        end
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_sel         <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fill        <= '0;
            r_head        <= '0;
            r_err_over    <= 1'b0;
            r_err_outside <= 1'b0;
        end else begin
            if (start_burst) begin
                r_sel <= w_hit;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end

            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FILL_ONE;
                2'b01:   r_fill <= r_fill - FILL_ONE;
                default: r_fill <= r_fill;
            endcase

            // Head register mirrors the entry at the read pointer; when the FIFO
            // holds at most one entry the incoming word bypasses the array.
            if (w_pop) begin
                if (r_fill > FILL_ONE) begin
                    r_head <= r_mem[w_rd_next];
                end else if (w_push) begin
                    r_head <= w_cmd;
                end
            end else if ((r_fill == FILL_ZERO) && w_push) begin
                r_head <= w_cmd;
            end

            r_err_over    <= w_over_set    | (r_err_over    & ~err_clr);
            r_err_outside <= w_outside_set | (r_err_outside & ~err_clr);
        end
    end

    always_comb begin
        dev_ready                     = (r_fill <= READY_LIMIT);
        cmd_valid                     = (r_fill != FILL_ZERO);
        {cmd_addr, cmd_stb, cmd_data} = r_head;
        fill                          = r_fill;
        err_over                      = r_err_over;
        err_outside                   = r_err_outside;
    end

endmodule
